// File: rtl/ram_fill_writer.sv
// Walks every RAM address after a start pulse and writes a mode-selected pattern, one write per TICK_DIV cycles.
// start is only accepted in IDLE; a fill cannot be interrupted except by Reset.
module ram_fill_writer #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 4,
    parameter int TICK_DIV = 100
) (
    input  logic              CLOCK_50,
    input  logic              Reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wren,
    output logic              busy,
    output logic              done
);
    localparam int                CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [1:0]        mode_q, mode_nxt;
    logic [DATA_W-1:0] seed_q, seed_nxt;
    logic [DATA_W-1:0] addr_d;

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state  <= IDLE;
            addr   <= '0;
            cnt    <= '0;
            mode_q <= '0;
            seed_q <= '0;
        end else begin
            state  <= state_nxt;
            addr   <= addr_nxt;
            cnt    <= cnt_nxt;
            mode_q <= mode_nxt;
            seed_q <= seed_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        cnt_nxt   = cnt;
        mode_nxt  = mode_q;
        seed_nxt  = seed_q;
        wren      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FILL;
                    addr_nxt  = '0;
                    cnt_nxt   = '0;
                    mode_nxt  = mode;
                    seed_nxt  = seed;
                end
            end
            FILL: begin
                busy    = 1'b1;
                cnt_nxt = cnt + CNT_W'(1);
                // Last cycle of the slot carries the write; no wrap past the top address.
                if (cnt == CNT_LAST) begin
                    wren    = 1'b1;
                    cnt_nxt = '0;
                    if (addr == ADDR_LAST) state_nxt = DONE;
                    else                   addr_nxt  = addr + ADDR_W'(1);
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address is truncated or zero-extended to the data width before pattern arithmetic.
    assign addr_d = DATA_W'(addr);

    always_comb begin
        wr_data = seed_q;
        case (mode_q)
            2'd0:    wr_data = seed_q;
            2'd1:    wr_data = addr_d;
            2'd2:    wr_data = seed_q + addr_d;
            default: wr_data = ~addr_d;
        endcase
    end

    assign wr_addr = addr;

endmodule

// File: tb/tb_ram_fill_writer.sv
// Directed bench for ram_fill_writer: scoreboard of expected writes, checked as the DUTs write.
module tb_ram_fill_writer;
    typedef struct {
        logic [4:0] addr;
        logic [3:0] data;
        int         cyc;
    } ent_t;

    logic       CLOCK_50 = 1'b0;
    logic       reset4, start4, wren4, busy4, done4;
    logic [1:0] mode4;
    logic [3:0] seed4, wr_data4;
    logic [4:0] wr_addr4;
    logic       reset1, start1, wren1, busy1, done1;
    logic [1:0] mode1;
    logic [3:0] seed1, wr_data1;
    logic [4:0] wr_addr1;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    ent_t q4[$];
    ent_t q1[$];
    ent_t e4, e1;
    int   exp_done4 = -1, exp_done1 = -1;
    int   done_cnt4 = 0, done_cnt1 = 0;
    int   run1 = 0, max_run1 = 0;
    logic [3:0] ram4 [32];
    logic [3:0] ram1 [32];

    ram_fill_writer #(.ADDR_W(5), .DATA_W(4), .TICK_DIV(4)) u_dut4 (
        .CLOCK_50(CLOCK_50), .Reset(reset4), .start(start4), .mode(mode4), .seed(seed4),
        .wr_addr(wr_addr4), .wr_data(wr_data4), .wren(wren4), .busy(busy4), .done(done4)
    );

    ram_fill_writer #(.ADDR_W(5), .DATA_W(4), .TICK_DIV(1)) u_dut1 (
        .CLOCK_50(CLOCK_50), .Reset(reset1), .start(start1), .mode(mode1), .seed(seed1),
        .wr_addr(wr_addr1), .wr_data(wr_data1), .wren(wren1), .busy(busy1), .done(done1)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic logic [3:0] pat(input logic [1:0] m, input logic [3:0] s, input logic [3:0] a);
        case (m)
            2'd0:    return s;
            2'd1:    return a;
            2'd2:    return s + a;
            default: return ~a;
        endcase
    endfunction

    task automatic push(input bit to1, input logic [1:0] m, input logic [3:0] s, input int sc);
        int td = to1 ? 1 : 4;
        for (int n = 0; n < 32; n++) begin
            ent_t e;
            e.addr = n[4:0];
            e.data = pat(m, s, n[3:0]);
            e.cyc  = sc + (n + 1) * td - 1;
            if (to1) q1.push_back(e);
            else     q4.push_back(e);
        end
        if (to1) exp_done1 = sc + 32 * td;
        else     exp_done4 = sc + 32 * td;
    endtask

    // Pulse start for one edge, then scramble mode/seed so only the latched copies can be used.
    task automatic start_fill(input bit to1, input logic [1:0] m, input logic [3:0] s);
        if (to1) begin mode1 = m; seed1 = s; start1 = 1'b1; end
        else     begin mode4 = m; seed4 = s; start4 = 1'b1; end
        tick();
        if (to1) begin start1 = 1'b0; mode1 = ~m; seed1 = ~s; end
        else     begin start4 = 1'b0; mode4 = ~m; seed4 = ~s; end
        push(to1, m, s, cyc);
    endtask

    task automatic wait_done(input bit to1, input int budget, input string tag);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge CLOCK_50);
            seen = to1 ? (done1 === 1'b1) : (done4 === 1'b1);
            n++;
        end
        check(tag, seen, 1);
        tick();
    endtask

    always @(negedge CLOCK_50) begin
        if (wren4 === 1'b1) begin
            if (q4.size() == 0) check("w4_unexpected", 1, 0);
            else begin
                e4 = q4.pop_front();
                check("w4_addr", wr_addr4, e4.addr);
                check("w4_data", wr_data4, e4.data);
                check("w4_cycle", cyc, e4.cyc);
                ram4[wr_addr4] = wr_data4;
            end
        end
        if (done4 === 1'b1) begin
            done_cnt4++;
            check("done4_cycle", cyc, exp_done4);
            check("done4_busy", busy4, 0);
            check("done4_q_empty", q4.size(), 0);
        end
    end

    always @(negedge CLOCK_50) begin
        if (wren1 === 1'b1) begin
            run1++;
            if (run1 > max_run1) max_run1 = run1;
            if (q1.size() == 0) check("w1_unexpected", 1, 0);
            else begin
                e1 = q1.pop_front();
                check("w1_addr", wr_addr1, e1.addr);
                check("w1_data", wr_data1, e1.data);
                check("w1_cycle", cyc, e1.cyc);
                ram1[wr_addr1] = wr_data1;
            end
        end else begin
            run1 = 0;
        end
        if (done1 === 1'b1) begin
            done_cnt1++;
            check("done1_cycle", cyc, exp_done1);
            check("done1_q_empty", q1.size(), 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int c2;
        int done_before;
        reset4 = 1'b1; reset1 = 1'b1;
        start4 = 1'b0; start1 = 1'b0;
        mode4  = 2'd0; mode1  = 2'd0;
        seed4  = 4'h0; seed1  = 4'h0;
        repeat (2) tick();
        @(negedge CLOCK_50);
        check("rst_wren", wren4, 0);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_addr", wr_addr4, 0);
        check("rst_data", wr_data4, 0);
        check("rst_busy1", busy1, 0);

        // Reset and start at the same edge: reset wins.
        start4 = 1'b1; mode4 = 2'd1; seed4 = 4'h9;
        tick();
        start4 = 1'b0; reset4 = 1'b0; reset1 = 1'b0;
        @(negedge CLOCK_50);
        check("rst_start_busy", busy4, 0);
        check("rst_start_wren", wren4, 0);
        tick();

        // Mode 0, seed A.
        start_fill(1'b0, 2'd0, 4'hA);
        @(negedge CLOCK_50);
        check("m0_busy", busy4, 1);
        wait_done(1'b0, 200, "m0_done_seen");
        check("m0_done_count", done_cnt4, 1);
        for (int i = 0; i < 32; i++) check("m0_ram", ram4[i], 4'hA);

        // Mode 2, seed E: data wraps mod 16.
        start_fill(1'b0, 2'd2, 4'hE);
        wait_done(1'b0, 200, "m2_done_seen");
        check("m2_a0", ram4[0], 4'hE);
        check("m2_a1", ram4[1], 4'hF);
        check("m2_a2", ram4[2], 4'h0);
        check("m2_a17", ram4[17], 4'hF);
        check("m2_a31", ram4[31], 4'hD);

        // TICK_DIV=1, mode 3.
        start_fill(1'b1, 2'd3, 4'h6);
        wait_done(1'b1, 60, "t1_done_seen");
        check("t1_run_len", max_run1, 32);
        check("t1_a0", ram1[0], 4'hF);
        check("t1_a5", ram1[5], 4'hA);
        check("t1_a31", ram1[31], 4'h0);
        check("t1_done_count", done_cnt1, 1);

        // Start pulse mid-fill is ignored; then start held high across done.
        start_fill(1'b0, 2'd2, 4'h7);
        repeat (42) tick();
        check("busy_addr10", wr_addr4, 10);
        mode4 = 2'd1; seed4 = 4'h0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (2) tick();
        mode4 = 2'd1; seed4 = 4'h3; start4 = 1'b1;
        wait_done(1'b0, 200, "held_first_done");
        seen = 0;
        c2   = 0;
        for (int k = 0; k < 3 && seen == 0; k++) begin
            @(negedge CLOCK_50);
            if (busy4 === 1'b1) begin seen = 1; c2 = cyc; end
        end
        check("held_restart", seen, 1);
        start4 = 1'b0;
        if (seen == 1) push(1'b0, 2'd1, 4'h3, c2);
        wait_done(1'b0, 200, "held_second_done");
        check("held_a10", ram4[10], 4'hA);
        check("held_a31", ram4[31], 4'hF);

        // Reset after the write to address 12.
        start_fill(1'b0, 2'd0, 4'h5);
        repeat (52) tick();
        check("pre_reset_left", q4.size(), 19);
        reset4 = 1'b1;
        tick();
        q4.delete();
        reset4 = 1'b0;
        @(negedge CLOCK_50);
        check("midrst_wren", wren4, 0);
        check("midrst_busy", busy4, 0);
        check("midrst_done", done4, 0);
        done_before = done_cnt4;
        repeat (150) tick();
        check("midrst_no_done", done_cnt4, done_before);
        check("midrst_a12", ram4[12], 4'h5);
        check("midrst_a13", ram4[13], 4'hD);

        // Refill after the aborted fill.
        start_fill(1'b0, 2'd1, 4'h0);
        wait_done(1'b0, 200, "refill_done_seen");
        for (int i = 0; i < 32; i++) check("refill_ram", ram4[i], i[3:0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_fill_writer.md
Name: ram_fill_writer

Overview:
- Writer-side counterpart to the 1 Hz address-sweep display reader. On a start pulse, it walks every address of the 32x4 single-port RAM and writes a selected data pattern, so the reader has known contents to display.
- Paced by an internal tick divider, so the fill can run at human-visible speed on hardware and at short tick periods in simulation.
- Connects directly to the RAM address/data/wren pins, muxed against switch-driven manual writes at the top level.

Parameters:
- ADDR_W, 5, address width; the fill covers addresses 0 .. 2^ADDR_W-1.
- DATA_W, 4, RAM data width.
- TICK_DIV, 100, clock cycles per write slot; legal values are >= 1.

Ports:
- CLOCK_50  input  1  system clock, all logic on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- start  input  1  fill request, sampled on each rising edge.
- mode  input  2  pattern select, latched when start is accepted.
- seed  input  DATA_W  pattern seed, latched when start is accepted.
- wr_addr  output  ADDR_W  RAM write address.
- wr_data  output  DATA_W  RAM write data.
- wren  output  1  RAM write enable; one cycle per address.
- busy  output  1  high while a fill is in progress.
- done  output  1  one-cycle pulse after the last write.

Behaviour:
- Reset is synchronous and active-high; the clock is CLOCK_50.
- Reset values: state=IDLE, wren=0, busy=0, done=0, wr_addr=0, tick counter=0, latched mode=0, latched seed=0. Therefore wr_data=0.
- States: IDLE, FILL, DONE.
- IDLE:
  - busy=0.
  - If start=1 at an edge: latch mode/seed, set addr=0 and cnt=0, go to FILL.
- FILL:
  - busy=1.
  - cnt increments each edge.
  - wren=1 combinationally while cnt==TICK_DIV-1.
  - At that edge: cnt<=0. If addr==2^ADDR_W-1, go to DONE; otherwise addr<=addr+1.
  - There is no wrap past the top address. Exactly 2^ADDR_W writes occur, each exactly once, in ascending order.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then return to IDLE.
  - wr_addr holds the last address until the next start.
- Timing: if start is accepted at edge k, write n (n=0..31) has wren high in the cycle between edges k+(n+1)*TICK_DIV-1 and k+(n+1)*TICK_DIV.
  - With TICK_DIV=1, wren stays high for 32 consecutive cycles.
  - The done pulse occupies the cycle immediately after the last write edge.
- start while in FILL or DONE is ignored. Latched mode/seed do not change mid-fill.
- start held high continuously: a new fill is accepted in IDLE, on the edge after the done cycle.
- wr_data patterns (addr truncated/zero-extended to DATA_W, all arithmetic mod 2^DATA_W):
  - mode 0: seed.
  - mode 1: addr.
  - mode 2: seed + addr.
  - mode 3: ~addr.
- wr_addr/wr_data are stable for the whole write slot, not only the wren cycle.
- Reset during FILL: at the reset edge, return to IDLE and drop wren/busy in the following cycle. No done pulse is generated. Partially written RAM contents are not restored.
- Reset and start at the same edge: Reset wins, state=IDLE.

Test Plan:
- Reset check (TICK_DIV=4): hold Reset 2 cycles -> wren=0, busy=0, done=0, wr_addr=0, wr_data=0.
- Mode 0 fill (TICK_DIV=4): start pulse with mode=0, seed=4'hA.
  - Exactly 32 wren pulses, 4 cycles apart.
  - Addresses 0..31 in order, all data=4'hA.
  - done pulses once, 128 cycles after the start edge.
  - Scoreboard RAM model then holds A at every address.
- Mode 2 wrap: mode=2, seed=4'hE.
  - addr 0 -> E, addr 1 -> F, addr 2 -> 0, addr 17 -> F, addr 31 -> D.
- TICK_DIV=1, mode=3:
  - wren high for 32 consecutive cycles.
  - addr 0 -> F, addr 5 -> A, addr 31 -> 0.
  - done pulse in the next cycle.
- Start while busy and start held:
  - Pulse start with mode=1 at address 10 -> ignored; data still follows the first fill's mode.
  - Holding start high -> second fill begins the cycle after done.
- Mid-fill reset: assert Reset after the write to address 12.
  - Next cycle: wren=0, busy=0, no done pulse.
  - A following start with mode=1 refills addresses 0..31 with data=addr[3:0].
